// File: rtl/dmem_resp.sv
// Data-memory responder: byte-lane store merge, aligned/extended loads, fixed latency.
// Optional misaligned-access exception enabled by DMEM_MISALIGN_CHK_EN.
module dmem_resp #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_flush,
    input  logic            mem_re,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [4:0]      mem_l_mask,
    input  logic [3:0]      mem_byte_we,
    input  logic [XLEN-1:0] mem_wdata,
    output logic [XLEN-1:0] mem_rdata,
    output logic            mem_rvalid,
    output logic            mem_busy,
    output logic            mem_exp_flag
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [2:0] CNT_INIT = 3'(LATENCY > 1 ? LATENCY - 2 : 0);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic [1:0]      state;
    logic [2:0]      cnt;
    logic [XLEN-1:0] word_q;
    logic [1:0]      off_q;
    logic [4:0]      mask_q;
    logic            mis_q;
    logic            st_exp_q;
    logic [XLEN-1:0] rdata_q;

    logic [AW-1:0]   idx;
    logic [XLEN-1:0] rd_word;
    logic [XLEN-1:0] lane;
    logic [2:0]      nbytes;
    logic            can_acc;
    logic            st_acc;
    logic            ld_acc;
    logic            ld_mis;
    logic            st_mis;
    logic            unused_addr;

    assign idx         = mem_addr[AW+1:2];
    assign rd_word     = mem[idx];
    assign unused_addr = ^mem_addr[XLEN-1:AW+2];

    assign nbytes = {2'b0, mem_byte_we[0]} + {2'b0, mem_byte_we[1]}
                  + {2'b0, mem_byte_we[2]} + {2'b0, mem_byte_we[3]};

    always_comb begin
        lane = mem_wdata;
        case (nbytes)
            3'd1:    lane = {4{mem_wdata[7:0]}};
            3'd2:    lane = {2{mem_wdata[15:0]}};
            default: lane = mem_wdata;
        endcase
    end

`ifdef DMEM_MISALIGN_CHK_EN
    assign ld_mis = ((mem_l_mask[1] | mem_l_mask[4]) & mem_addr[0])
                  | (mem_l_mask[2] & (mem_addr[1:0] != 2'b00));
    assign st_mis = ((nbytes == 3'd2) & mem_addr[0])
                  | ((nbytes == 3'd4) & (mem_addr[1:0] != 2'b00));
`else
    assign ld_mis = 1'b0;
    assign st_mis = 1'b0;
`endif

    // RESP accepts back-to-back; a store wins over a simultaneous load
    assign can_acc = (state == IDLE) | (state == RESP);
    assign st_acc  = rst_n & can_acc & mem_we;
    assign ld_acc  = can_acc & mem_re & ~mem_we & ~pipe_flush;

    function automatic logic [XLEN-1:0] extract(
        input logic [XLEN-1:0] w,
        input logic [1:0]      off,
        input logic [4:0]      m
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (m)
            5'b00001: extract = {{(XLEN-8){b[7]}}, b};
            5'b00010: extract = {{(XLEN-16){h[15]}}, h};
            5'b00100: extract = w;
            5'b01000: extract = {{(XLEN-8){1'b0}}, b};
            5'b10000: extract = {{(XLEN-16){1'b0}}, h};
            default:  extract = '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (st_acc && !st_mis) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_byte_we[i])
                    mem[idx][8*i +: 8] <= lane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            word_q   <= '0;
            off_q    <= '0;
            mask_q   <= '0;
            mis_q    <= 1'b0;
            st_exp_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            st_exp_q <= st_acc & st_mis;
            if (ld_acc) begin
                word_q <= rd_word;
                off_q  <= mem_addr[1:0];
                mask_q <= mem_l_mask;
                mis_q  <= ld_mis;
                if (LATENCY == 1) begin
                    state <= RESP;
                    if (!ld_mis)
                        rdata_q <= extract(rd_word, mem_addr[1:0], mem_l_mask);
                end else begin
                    state <= WAIT;
                    cnt   <= CNT_INIT;
                end
            end else if (pipe_flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    WAIT: begin
                        if (cnt == 3'd0) begin
                            state <= RESP;
                            if (!mis_q)
                                rdata_q <= extract(word_q, off_q, mask_q);
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign mem_rdata    = rdata_q;
    assign mem_busy     = (state == WAIT);
    assign mem_rvalid   = (state == RESP) & ~mis_q & ~pipe_flush;
    assign mem_exp_flag = st_exp_q | ((state == RESP) & mis_q & ~pipe_flush);

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: one instance at LATENCY=1, one at LATENCY=3.
module tb_dmem_resp;

    localparam logic [4:0] LB  = 5'b00001;
    localparam logic [4:0] LH  = 5'b00010;
    localparam logic [4:0] LW  = 5'b00100;
    localparam logic [4:0] LBU = 5'b01000;
    localparam logic [4:0] LHU = 5'b10000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_flush;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [4:0]  mem_l_mask;
    logic [3:0]  mem_byte_we;
    logic [31:0] mem_wdata;

    logic [31:0] r1_data, r3_data;
    logic        r1_valid, r3_valid;
    logic        r1_busy, r3_busy;
    logic        r1_exp, r3_exp;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dmem_resp #(.XLEN(32), .DEPTH_WORDS(4096), .LATENCY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_l_mask(mem_l_mask), .mem_byte_we(mem_byte_we),
        .mem_wdata(mem_wdata), .mem_rdata(r1_data),
        .mem_rvalid(r1_valid), .mem_busy(r1_busy), .mem_exp_flag(r1_exp)
    );

    dmem_resp #(.XLEN(32), .DEPTH_WORDS(4096), .LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_l_mask(mem_l_mask), .mem_byte_we(mem_byte_we),
        .mem_wdata(mem_wdata), .mem_rdata(r3_data),
        .mem_rvalid(r3_valid), .mem_busy(r3_busy), .mem_exp_flag(r3_exp)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic step(input logic re, input logic we, input logic [31:0] a,
                        input logic [4:0] m, input logic [3:0] be,
                        input logic [31:0] d);
        mem_re      = re;
        mem_we      = we;
        mem_addr    = a;
        mem_l_mask  = m;
        mem_byte_we = be;
        mem_wdata   = d;
        @(posedge clk);
        @(negedge clk);
        mem_re = 1'b0;
        mem_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; pipe_flush = 1'b0;
        mem_re = 1'b0; mem_we = 1'b0; mem_addr = '0;
        mem_l_mask = '0; mem_byte_we = '0; mem_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_rvalid", {31'b0, r1_valid}, 32'd0);
        check("rst_busy", {31'b0, r3_busy}, 32'd0);
        check("rst_rdata", r1_data, 32'd0);
        check("rst_exp", {31'b0, r1_exp}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        step(0, 1, 32'h10, '0, 4'b1111, 32'h8899AABB);
        check("sw_no_rvalid", {31'b0, r1_valid}, 32'd0);
        check("sw_no_busy", {31'b0, r1_busy}, 32'd0);
        check("sw_no_exp", {31'b0, r1_exp}, 32'd0);
        step(1, 0, 32'h10, LW, '0, '0);
        check("lw_rvalid", {31'b0, r1_valid}, 32'd1);
        check("lw_data", r1_data, 32'h8899AABB);
        idle(3);

        step(0, 1, 32'h10, '0, 4'b1111, 32'h11223344);
        step(0, 1, 32'h13, '0, 4'b1000, 32'h000000F0);
        step(1, 0, 32'h13, LB, '0, '0);
        check("lb_data", r1_data, 32'hFFFFFFF0);
        step(1, 0, 32'h13, LBU, '0, '0);
        check("lbu_valid", {31'b0, r1_valid}, 32'd1);
        check("lbu_data", r1_data, 32'h000000F0);
        step(1, 0, 32'h10, LW, '0, '0);
        check("lw_merge", r1_data, 32'hF0223344);
        idle(3);

        step(0, 1, 32'h20, '0, 4'b1111, 32'h5555AAAA);
        step(0, 1, 32'h22, '0, 4'b1100, 32'h00008001);
        step(1, 0, 32'h22, LH, '0, '0);
        check("lh_data", r1_data, 32'hFFFF8001);
        step(1, 0, 32'h23, LHU, '0, '0);
        check("lhu_data", r1_data, 32'h00008001);
        step(1, 0, 32'h20, LHU, '0, '0);
        check("lhu_low", r1_data, 32'h0000AAAA);
        step(1, 0, 32'h20, 5'b00011, '0, '0);
        check("badmask_valid", {31'b0, r1_valid}, 32'd1);
        check("badmask_data", r1_data, 32'd0);
        step(1, 0, 32'h4020, LW, '0, '0);
        check("wrap_data", r1_data, 32'h8001AAAA);
        idle(1);
        check("hold_valid", {31'b0, r1_valid}, 32'd0);
        check("hold_data", r1_data, 32'h8001AAAA);
        idle(3);

        step(1, 1, 32'h30, LW, 4'b1111, 32'hDEADBEEF);
        check("rewe_no_rvalid", {31'b0, r1_valid}, 32'd0);
        step(1, 0, 32'h30, LW, '0, '0);
        check("rewe_store", r1_data, 32'hDEADBEEF);
        step(0, 1, 32'h30, '0, 4'b0000, 32'h0);
        check("be0_no_rvalid", {31'b0, r1_valid}, 32'd0);
        step(1, 0, 32'h30, LW, '0, '0);
        check("be0_noop", r1_data, 32'hDEADBEEF);

        step(1, 0, 32'h10, LW, '0, '0);
        pipe_flush = 1'b1;
        #1;
        check("l1_flush_resp", {31'b0, r1_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        pipe_flush = 1'b0;
        check("l1_flush_after", {31'b0, r1_valid}, 32'd0);
        idle(4);

        step(0, 1, 32'h40, '0, 4'b1111, 32'hCAFEF00D);
        step(0, 1, 32'h44, '0, 4'b1111, 32'h12345678);

        mem_re = 1'b1; mem_addr = 32'h40; mem_l_mask = LW;
        @(posedge clk);
        @(negedge clk);
        check("l3_busy_t1", {31'b0, r3_busy}, 32'd1);
        check("l3_novalid_t1", {31'b0, r3_valid}, 32'd0);
        mem_addr = 32'h44;
        @(posedge clk);
        @(negedge clk);
        check("l3_busy_t2", {31'b0, r3_busy}, 32'd1);
        check("l3_novalid_t2", {31'b0, r3_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("l3_valid_t3", {31'b0, r3_valid}, 32'd1);
        check("l3_data_t3", r3_data, 32'hCAFEF00D);
        check("l3_nobusy_t3", {31'b0, r3_busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        mem_re = 1'b0;
        check("l3_2nd_busy", {31'b0, r3_busy}, 32'd1);
        idle(2);
        check("l3_2nd_valid", {31'b0, r3_valid}, 32'd1);
        check("l3_2nd_data", r3_data, 32'h12345678);
        idle(1);

        mem_re = 1'b1; mem_addr = 32'h40; mem_l_mask = LW;
        @(posedge clk);
        @(negedge clk);
        mem_re = 1'b0;
        check("fl_busy", {31'b0, r3_busy}, 32'd1);
        pipe_flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pipe_flush = 1'b0;
        check("fl_nobusy", {31'b0, r3_busy}, 32'd0);
        check("fl_hold", r3_data, 32'h12345678);
        for (int i = 0; i < 3; i++) begin
            check("fl_novalid", {31'b0, r3_valid}, 32'd0);
            @(negedge clk);
        end

        mem_re = 1'b1; mem_addr = 32'h40; mem_l_mask = LW;
        @(posedge clk);
        @(negedge clk);
        mem_re = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rs_nobusy", {31'b0, r3_busy}, 32'd0);
        check("rs_rdata", r3_data, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("rs_novalid", {31'b0, r3_valid}, 32'd0);
            @(negedge clk);
        end

        step(1, 0, 32'h40, LW, '0, '0);
        idle(2);
        check("rs_mem_kept_v", {31'b0, r3_valid}, 32'd1);
        check("rs_mem_kept", r3_data, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
